// File: rtl/core_pkg.sv
// core_pkg: shared types and defaults for the core and its instruction-memory loader.
// Holds the loader state encoding, the core data width and the default IMEM depth,
// plus the header range checks used by the loader.
package core_pkg;

   localparam int CORE_DATA_WIDTH = 32;
   localparam int CORE_IMEM_DEPTH = 1024;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR_CNT = 3'd1,
      ST_HDR_PC  = 3'd2,
      ST_LOAD    = 3'd3,
      ST_CHK     = 3'd4,
      ST_START   = 3'd5,
      ST_DONE    = 3'd6,
      ST_ERR     = 3'd7
   } loader_state_e;

   // Word count must be non-zero and no larger than the memory.
   function automatic logic count_ok(input logic [31:0] n, input logic [31:0] depth);
      return (n != 32'd0) && (n <= depth);
   endfunction

   // The image starting at word index pc_word must end inside the memory (no wrap).
   function automatic logic span_ok(input logic [29:0] pc_word, input logic [31:0] n,
                                    input logic [31:0] depth);
      logic [32:0] end_s;
      end_s = {3'b000, pc_word} + {1'b0, n};
      return (end_s <= {1'b0, depth});
   endfunction

endpackage

// File: rtl/imem_loader_byte_word_assembler.sv
// byte_word_assembler: collects four stream bytes little-endian into one 32-bit word.
// word_valid pulses in the same cycle the 4th byte is accepted; word is valid then.
module byte_word_assembler (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic        word_valid_o,
   output logic [31:0] word_o
);

   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] sr_q, sr_d;

   // Next byte count and shift-register contents; lower bytes arrive first.
   always_comb begin
      cnt_d = cnt_q;
      sr_d  = sr_q;
      if (clr_i) begin
         cnt_d = 2'd0;
         sr_d  = 24'd0;
      end else if (byte_valid_i) begin
         cnt_d = cnt_q + 2'd1;
         sr_d  = {byte_i, sr_q[23:8]};
      end else begin
         cnt_d = cnt_q;
         sr_d  = sr_q;
      end
   end

   // Byte counter and shift register, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= 2'd0;
         sr_q  <= 24'd0;
      end else begin
         cnt_q <= cnt_d;
         sr_q  <= sr_d;
      end
   end

   assign word_valid_o = byte_valid_i && (cnt_q == 2'd3) && !clr_i;
   assign word_o       = {byte_i, sr_q};

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a little-endian byte stream (count, start PC, payload words)
// into instruction memory, then points the core at the start PC and releases it.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing 32-bit sum check.
module imem_loader
   import core_pkg::*;
#(
   parameter int DATA_WIDTH = CORE_DATA_WIDTH,
   parameter int IMEM_DEPTH = CORE_IMEM_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          load_start,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [7:0]                    s_data,
   output logic                          imem_we,
   output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
   output logic [DATA_WIDTH-1:0]         imem_wdata,
   output logic                          pc_we,
   output logic [DATA_WIDTH-1:0]         pc_o,
   output logic                          core_hold,
   output logic                          done,
   output logic                          err
);

   localparam int AW = $clog2(IMEM_DEPTH);

   loader_state_e         state_q, state_d;
   logic [AW:0]           n_q, n_d;
   logic [AW:0]           wcnt_q, wcnt_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic                  s_ready_q, s_ready_d;
   logic                  imem_we_q, imem_we_d;
   logic [AW-1:0]         imem_addr_q, imem_addr_d;
   logic [DATA_WIDTH-1:0] imem_wdata_q, imem_wdata_d;
   logic                  pc_we_q, pc_we_d;
   logic [DATA_WIDTH-1:0] pc_o_q, pc_o_d;
   logic                  core_hold_q, core_hold_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0]           sum_q, sum_d;
`endif

   logic                  byte_fire_s;
   logic                  start_ok_s;
   logic                  word_valid_s;
   logic [31:0]           word_s;
   logic                  last_word_s;

   // s_ready is a registered copy of "state accepts bytes", so it gates the transfer directly.
   assign byte_fire_s = s_valid && s_ready_q;
   assign start_ok_s  = load_start &&
                        ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
   assign last_word_s = ((wcnt_q + (AW+1)'(1)) == n_q);

   byte_word_assembler u_asm (
      .clk          (clk),
      .rst_n        (rst_n),
      .clr_i        (start_ok_s),
      .byte_valid_i (byte_fire_s),
      .byte_i       (s_data),
      .word_valid_o (word_valid_s),
      .word_o       (word_s)
   );

   // Session state machine: header checks, payload counting and optional checksum.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      wcnt_d  = wcnt_q;
      pc_d    = pc_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start_ok_s) begin
               state_d = ST_HDR_CNT;
               wcnt_d  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d   = 32'd0;
`endif
            end else begin
               state_d = state_q;
            end
         end
         ST_HDR_CNT: begin
            if (word_valid_s) begin
               if (!count_ok(word_s, 32'(IMEM_DEPTH))) begin
                  state_d = ST_ERR;
               end else begin
                  n_d     = word_s[AW:0];
                  state_d = ST_HDR_PC;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_HDR_PC: begin
            if (word_valid_s) begin
               if (word_s[1:0] != 2'b00) begin
                  state_d = ST_ERR;
               end else if (!span_ok(word_s[31:2], 32'(n_q), 32'(IMEM_DEPTH))) begin
                  state_d = ST_ERR;
               end else begin
                  pc_d    = DATA_WIDTH'(word_s);
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_LOAD: begin
            if (word_valid_s) begin
               wcnt_d = wcnt_q + (AW+1)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_d  = sum_q + word_s;
               if (last_word_s) begin
                  state_d = ST_CHK;
               end else begin
                  state_d = ST_LOAD;
               end
`else
               if (last_word_s) begin
                  state_d = ST_START;
               end else begin
                  state_d = ST_LOAD;
               end
`endif
            end else begin
               state_d = state_q;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHK: begin
            if (word_valid_s) begin
               if (word_s == sum_q) begin
                  state_d = ST_START;
               end else begin
                  state_d = ST_ERR;
               end
            end else begin
               state_d = state_q;
            end
         end
`endif
         ST_START: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered outputs: status follows the next state, strobes fire one cycle after their cause.
   always_comb begin
      s_ready_d    = (state_d == ST_HDR_CNT) || (state_d == ST_HDR_PC) ||
                     (state_d == ST_LOAD)    || (state_d == ST_CHK);
      core_hold_d  = s_ready_d || (state_d == ST_START) || (state_d == ST_ERR);
      done_d       = (state_d == ST_DONE);
      err_d        = (state_d == ST_ERR);
      imem_we_d    = (state_q == ST_LOAD) && word_valid_s;
      pc_we_d      = (state_q == ST_START);
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      pc_o_d       = pc_o_q;
      if (imem_we_d) begin
         imem_addr_d  = pc_q[AW+1:2] + wcnt_q[AW-1:0];
         imem_wdata_d = DATA_WIDTH'(word_s);
      end else begin
         imem_addr_d  = imem_addr_q;
         imem_wdata_d = imem_wdata_q;
      end
      if (pc_we_d) begin
         pc_o_d = pc_q;
      end else begin
         pc_o_d = pc_o_q;
      end
   end

   // State, session registers and output flops; reset abandons any session.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         n_q          <= '0;
         wcnt_q       <= '0;
         pc_q         <= '0;
         s_ready_q    <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         pc_we_q      <= 1'b0;
         pc_o_q       <= '0;
         core_hold_q  <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q        <= 32'd0;
`endif
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         wcnt_q       <= wcnt_d;
         pc_q         <= pc_d;
         s_ready_q    <= s_ready_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         pc_we_q      <= pc_we_d;
         pc_o_q       <= pc_o_d;
         core_hold_q  <= core_hold_d;
         done_q       <= done_d;
         err_q        <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q        <= sum_d;
`endif
      end
   end

   assign s_ready    = s_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign pc_we      = pc_we_q;
   assign pc_o       = pc_o_q;
   assign core_hold  = core_hold_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven sessions plus hand sequences for latency,
// reset mid-session, load_start mid-load and (when enabled) the checksum.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_start;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_data;
   logic        imem_we;
   logic [9:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        pc_we;
   logic [31:0] pc_o;
   logic        core_hold;
   logic        done;
   logic        err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   imem_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_start (load_start),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .pc_we      (pc_we),
      .pc_o       (pc_o),
      .core_hold  (core_hold),
      .done       (done),
      .err        (err)
   );

   // write / pc_we monitor, sampled away from the active edge
   logic [9:0]  wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          pcwe_cnt = 0;
   logic [31:0] last_pc = 32'd0;

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wr_addr_q.push_back(imem_addr);
         wr_data_q.push_back(imem_wdata);
      end
      if (pc_we === 1'b1) begin
         pcwe_cnt = pcwe_cnt + 1;
         last_pc  = pc_o;
      end
   end

   typedef struct {
      string       name;
      logic [31:0] n;
      logic [31:0] pc;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] w2;
      int          hdr_words;
      int          nw;
      int          gap;
      logic        exp_done;
      logic        exp_err;
      int          exp_writes;
      logic [9:0]  exp_addr0;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t;
      t = 0;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = b;
      while (!s_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("s_ready_wait", {31'd0, s_ready}, 32'd1);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int k = 0; k < 4; k++) begin
         repeat (gap) @(negedge clk);
         send_byte(w[8*k +: 8]);
      end
   endtask

   task automatic start_session(input string name);
      @(negedge clk);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      check({name, " start core_hold"}, {31'd0, core_hold}, 32'd1);
      check({name, " start s_ready"}, {31'd0, s_ready}, 32'd1);
      check({name, " start done/err"}, {30'd0, done, err}, 32'd0);
   endtask

   task automatic wait_end(input string name);
      int t;
      t = 0;
      while (!(done || err) && t < 40) begin
         @(negedge clk);
         t++;
      end
      check({name, " end reached"}, {31'd0, (done || err)}, 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v);
      int          bw;
      int          bp;
      logic [31:0] ws[3];
`ifdef IMEM_LOADER_CHECKSUM_EN
      logic [31:0] sum;
      sum = 32'd0;
`endif
      bw = wr_addr_q.size();
      bp = pcwe_cnt;
      ws[0] = v.w0;
      ws[1] = v.w1;
      ws[2] = v.w2;
      start_session(v.name);
      send_word(v.n, v.gap);
      if (v.hdr_words > 1) send_word(v.pc, v.gap);
      for (int i = 0; i < v.nw; i++) begin
         send_word(ws[i], v.gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum = sum + ws[i];
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (!v.exp_err) send_word(sum, v.gap);
`endif
      wait_end(v.name);
      check({v.name, " done"}, {31'd0, done}, {31'd0, v.exp_done});
      check({v.name, " err"}, {31'd0, err}, {31'd0, v.exp_err});
      check({v.name, " core_hold"}, {31'd0, core_hold}, {31'd0, v.exp_err});
      check({v.name, " writes"}, 32'(wr_addr_q.size() - bw), 32'(v.exp_writes));
      check({v.name, " pc_we count"}, 32'(pcwe_cnt - bp), v.exp_done ? 32'd1 : 32'd0);
      if (wr_addr_q.size() - bw == v.exp_writes) begin
         for (int i = 0; i < v.exp_writes; i++) begin
            check($sformatf("%s addr%0d", v.name, i), {22'd0, wr_addr_q[bw + i]},
                  {22'd0, v.exp_addr0 + 10'(i)});
            check($sformatf("%s data%0d", v.name, i), wr_data_q[bw + i], ws[i]);
         end
      end
      if (v.exp_done) check({v.name, " pc_o"}, last_pc, v.exp_pc);
   endtask

   initial begin
      int bw;
      int bp;

      vecs[0] = '{"basic",    32'd2,    32'h0,   32'h002081b3, 32'h06408213, 32'h0,
                  2, 2, 0, 1'b1, 1'b0, 2, 10'd0,   32'h0};
      vecs[1] = '{"stall",    32'd1,    32'h10,  32'h000F5337, 32'h0, 32'h0,
                  2, 1, 3, 1'b1, 1'b0, 1, 10'd4,   32'h10};
      vecs[2] = '{"n_zero",   32'd0,    32'h0,   32'h0, 32'h0, 32'h0,
                  1, 0, 0, 1'b0, 1'b1, 0, 10'd0,   32'h0};
      vecs[3] = '{"pc_misal", 32'd1,    32'h2,   32'h0, 32'h0, 32'h0,
                  2, 0, 0, 1'b0, 1'b1, 0, 10'd0,   32'h0};
      vecs[4] = '{"pc_span",  32'd2,    32'hFFC, 32'h0, 32'h0, 32'h0,
                  2, 0, 0, 1'b0, 1'b1, 0, 10'd0,   32'h0};
      vecs[5] = '{"n_big",    32'd1025, 32'h0,   32'h0, 32'h0, 32'h0,
                  1, 0, 0, 1'b0, 1'b1, 0, 10'd0,   32'h0};
      vecs[6] = '{"pc_last",  32'd1,    32'hFFC, 32'hCAFEF00D, 32'h0, 32'h0,
                  2, 1, 0, 1'b1, 1'b0, 1, 10'h3FF, 32'hFFC};
      vecs[7] = '{"three",    32'd3,    32'h20,  32'hA5A5A5A5, 32'h5A5A5A5A, 32'h01234567,
                  2, 3, 1, 1'b1, 1'b0, 3, 10'd8,   32'h20};

      rst_n      = 1'b0;
      load_start = 1'b0;
      s_valid    = 1'b0;
      s_data     = 8'd0;
      repeat (3) @(negedge clk);
      check("reset flags", {26'd0, s_ready, imem_we, pc_we, core_hold, done, err}, 32'd0);
      check("reset imem_addr", {22'd0, imem_addr}, 32'd0);
      check("reset imem_wdata", imem_wdata, 32'd0);
      check("reset pc_o", pc_o, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

`ifndef IMEM_LOADER_CHECKSUM_EN
      // latency: last byte at edge t -> imem_we in t+1, pc_we in t+2
      start_session("lat");
      send_word(32'd1, 0);
      send_word(32'h40, 0);
      send_word(32'hDEADBEEF, 0);
      check("lat imem_we t+1", {31'd0, imem_we}, 32'd1);
      check("lat pc_we t+1", {31'd0, pc_we}, 32'd0);
      check("lat imem_addr", {22'd0, imem_addr}, 32'd16);
      check("lat imem_wdata", imem_wdata, 32'hDEADBEEF);
      @(posedge clk); #1;
      check("lat imem_we t+2", {31'd0, imem_we}, 32'd0);
      check("lat pc_we t+2", {31'd0, pc_we}, 32'd1);
      check("lat pc_o", pc_o, 32'h40);
      check("lat core_hold t+2", {31'd0, core_hold}, 32'd0);
      @(posedge clk); #1;
      check("lat pc_we t+3", {31'd0, pc_we}, 32'd0);
      check("lat done", {31'd0, done}, 32'd1);
      repeat (2) @(negedge clk);
`endif

      // reset after the first of three words
      bw = wr_addr_q.size();
      bp = pcwe_cnt;
      start_session("rst_mid");
      send_word(32'd3, 0);
      send_word(32'h100, 0);
      send_word(32'h11111111, 0);
      repeat (2) @(negedge clk);
      check("rst_mid pre addr", {22'd0, imem_addr}, 32'h40);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("rst_mid flags", {26'd0, s_ready, imem_we, pc_we, core_hold, done, err}, 32'd0);
      check("rst_mid imem_addr", {22'd0, imem_addr}, 32'd0);
      check("rst_mid imem_wdata", imem_wdata, 32'd0);
      check("rst_mid pc_o", pc_o, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("rst_mid writes", 32'(wr_addr_q.size() - bw), 32'd1);
      check("rst_mid pc_we", 32'(pcwe_cnt - bp), 32'd0);
      check("rst_mid idle", {30'd0, s_ready, core_hold}, 32'd0);
      run_vec(vecs[0]);

      // load_start during LOAD must be ignored
      bw = wr_addr_q.size();
      bp = pcwe_cnt;
      start_session("ls_mid");
      send_word(32'd2, 0);
      send_word(32'h8, 0);
      send_word(32'h00000AAA, 0);
      @(negedge clk);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      check("ls_mid still loading", {30'd0, s_ready, core_hold}, 32'd3);
      send_word(32'h00000BBB, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_word(32'h00001665, 0);
`endif
      wait_end("ls_mid");
      check("ls_mid done", {31'd0, done}, 32'd1);
      check("ls_mid writes", 32'(wr_addr_q.size() - bw), 32'd2);
      check("ls_mid pc_we", 32'(pcwe_cnt - bp), 32'd1);
      check("ls_mid pc_o", last_pc, 32'h8);
      if (wr_addr_q.size() - bw == 2) begin
         check("ls_mid addr1", {22'd0, wr_addr_q[bw + 1]}, 32'd3);
         check("ls_mid data1", wr_data_q[bw + 1], 32'h00000BBB);
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      // checksum good / bad
      for (int c = 0; c < 2; c++) begin
         bw = wr_addr_q.size();
         bp = pcwe_cnt;
         start_session("csum");
         send_word(32'd2, 0);
         send_word(32'h0, 0);
         send_word(32'h1, 0);
         send_word(32'h2, 0);
         send_word((c == 0) ? 32'h3 : 32'h4, 0);
         wait_end("csum");
         check($sformatf("csum%0d done", c), {31'd0, done}, (c == 0) ? 32'd1 : 32'd0);
         check($sformatf("csum%0d err", c), {31'd0, err}, (c == 0) ? 32'd0 : 32'd1);
         check($sformatf("csum%0d pc_we", c), 32'(pcwe_cnt - bp), (c == 0) ? 32'd1 : 32'd0);
         check($sformatf("csum%0d writes", c), 32'(wr_addr_q.size() - bw), 32'd2);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction/PC word width; taken from core_pkg.
REQ-002 Parameter IMEM_DEPTH, default 1024, instruction-memory depth in words.
REQ-003 clk  input  1  single clock; every register updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 load_start  input  1  one-cycle pulse that begins a load session.
REQ-006 s_valid  input  1  byte-stream data valid.
REQ-007 s_ready  output  1  byte-stream ready; a byte transfers when s_valid and s_ready are both 1.
REQ-008 s_data  input  8  stream byte.
REQ-009 imem_we  output  1  instruction-memory write strobe.
REQ-010 imem_addr  output  $clog2(IMEM_DEPTH)  word index.
REQ-011 imem_wdata  output  DATA_WIDTH  instruction word.
REQ-012 pc_we  output  1  drives the core's pc_we.
REQ-013 pc_o  output  DATA_WIDTH  drives the core's pc_i.
REQ-014 core_hold  output  1  holds the core pipeline while a session is active.
REQ-015 done  output  1  load completed.
REQ-016 err  output  1  load aborted.

Function
REQ-017 The state machine SHALL have states IDLE, HDR_CNT, HDR_PC, LOAD, CHK, START, DONE and ERR.
REQ-018 A load_start pulse in IDLE, DONE or ERR SHALL move to HDR_CNT, clear done and err, and set core_hold the next cycle.
- load_start in any other state SHALL be ignored.
REQ-019 Stream format, all fields little-endian 32-bit:
- word count N;
- start PC;
- N instruction words;
- checksum, only when enabled (REQ-031).
REQ-020 s_ready SHALL be 1 only in HDR_CNT, HDR_PC, LOAD and CHK.
- Each accepted byte SHALL shift into the assembler: byte k goes to bits [8k+7:8k], k = 0..3.
- A 2-bit byte counter SHALL wrap after the 4th byte.
REQ-021 Stalls on s_valid=0 SHALL be tolerated indefinitely with no state change.
REQ-022 HDR_CNT exit on the 4th byte:
- N==0 or N>IMEM_DEPTH: go to ERR;
- otherwise: go to HDR_PC.
REQ-023 HDR_PC exit on the 4th byte:
- PC[1:0]!=0: go to ERR;
- PC/4+N>IMEM_DEPTH: go to ERR (no address wrap permitted);
- otherwise: go to LOAD.
REQ-024 In LOAD, the cycle after each 4th byte SHALL pulse imem_we for exactly one cycle with:
- imem_addr = PC/4 + i, where i is the word number from 0;
- imem_wdata = the assembled word.
REQ-025 After word N-1, LOAD SHALL go to CHK if enabled, otherwise to START.
REQ-026 START SHALL assert pc_we for exactly one cycle with pc_o = start PC.
- core_hold SHALL drop in the same cycle.
- The next state SHALL be DONE.
REQ-027 DONE SHALL hold done=1 and ERR SHALL hold err=1 until the next load_start.
- In ERR: no imem_we, no pc_we, and core_hold stays 1.
REQ-028 Latency: the last byte accepted in cycle t produces imem_we in cycle t+1 and pc_we in cycle t+2 (checksum disabled).

Reset
REQ-029 While rst_n=0 at a clock edge:
- state SHALL become IDLE;
- byte counter, word counter and assembler SHALL clear;
- s_ready, imem_we, pc_we, core_hold, done and err SHALL be 0;
- imem_addr, imem_wdata and pc_o SHALL be 0.
REQ-030 Reset during a session SHALL abandon it without any further imem_we or pc_we.
- Words already written SHALL remain in memory.

Configuration
REQ-031 Macro IMEM_LOADER_CHECKSUM_EN, when defined:
- a 32-bit modulo-2^32 sum of all N payload words SHALL accumulate;
- CHK SHALL accept a 4-byte checksum;
- match goes to START, mismatch goes to ERR.
REQ-032 When IMEM_LOADER_CHECKSUM_EN is undefined, the CHK state and the accumulator SHALL be absent, and LOAD SHALL go directly to START.

Structure
REQ-033 core_pkg SHALL hold loader_state_e and the IMEM_DEPTH default; DATA_WIDTH SHALL be reused from core_pkg.
REQ-034 One sub-module, byte_word_assembler, SHALL contain the byte counter and shift register and emit a one-cycle word_valid.

Verification
REQ-035 Load with N=2, PC=0x0, words 0x002081b3 and 0x06408213 -> required response:
- imem writes at index 0 and index 1;
- one pc_we pulse with pc_o=0x0;
- done=1.
REQ-036 Load with N=1, PC=0x10, word 0x000F5337, with s_valid deasserted for 3 cycles between bytes -> single write at index 4, pc_o=0x10.
REQ-037 N=0, or PC=0x00000002, or PC=0xFFC with N=2 (IMEM_DEPTH=1024) -> required response:
- err=1;
- zero imem_we;
- zero pc_we.
REQ-038 rst_n driven low after 1 of 3 words -> required response:
- IDLE next cycle, all outputs 0;
- the following load_start session succeeds.
REQ-039 With the checksum enabled, words 0x1 and 0x2:
- checksum 0x3 -> done;
- checksum 0x4 -> err, no pc_we.
REQ-040 load_start pulsed mid-LOAD -> ignored; the session completes normally.
